sdspi_measure_ctrl: RTL and testbench
=====================================

Name: sdspi_measure_ctrl

Overview:
Upstream controller for the SD-SPI unit under test. It takes over the SPI pins through the mux select, holds the UUT in reset, applies a latched configuration, and pulses start. It then counts clk cycles until the UUT raises finish, or until a timeout expires. The registered result (cycle count, timeout flag) is presented for the debug display and the autotest logic.

Parameters:
RST_HOLD_CYCLES, 16, cycles sdspi_rst is held asserted after the mux switches to the UUT (minimum 1)
TIMEOUT_CYCLES, 32'd100000000, WAIT cycles after which the run aborts with timeout

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
go  in  1  one-cycle request to start a run; ignored while busy
cfg_n_blocks  in  32  block count, latched on accepted go
cfg_sclk_speed  in  5  SCLK divider select, latched on accepted go
cfg_cmd18  in  1  1 = multi-block read (CMD18), latched on accepted go
sdspi_ctrl_mux  out  1  0 = autotest drives SPI pins, 1 = UUT drives SPI pins
sdspi_rst  out  1  active-high reset to UUT
sdspi_start  out  1  one-cycle start pulse to UUT
sdspi_n_blocks  out  32  latched cfg_n_blocks
sdspi_sclk_speed  out  5  latched cfg_sclk_speed
sdspi_cmd18  out  1  latched cfg_cmd18
sdspi_finish  in  1  UUT completion level
busy  out  1  high from accepted go through DONE
done  out  1  one-cycle pulse at end of run
result_valid  out  1  cycles/timeout valid; cleared on accepted go
timeout  out  1  last run aborted
cycles  out  32  measured latency

Behaviour:
- Reset (rst=0, async) values:
  - sdspi_rst=1, sdspi_ctrl_mux=0, sdspi_start=0, busy=0, done=0, result_valid=0, timeout=0.
  - cycles=0, all latched config=0, state=IDLE.
- States: IDLE, RST_UUT, RELEASE, START, WAIT, DONE.
- IDLE: sdspi_rst=1, mux=0. go=1 at cycle 0:
  - latch cfg; clear result_valid, timeout, cycles.
  - busy=1, mux=1; go to RST_UUT.
- RST_UUT (cycles 1..RST_HOLD_CYCLES): sdspi_rst=1, mux=1, config outputs stable. Hold counter reaching RST_HOLD_CYCLES -> RELEASE.
- RELEASE (cycle H+1): sdspi_rst=0 for one settling cycle -> START.
- START (cycle H+2): sdspi_start=1 for exactly one cycle; latency counter loaded to 0 -> WAIT. sdspi_finish is ignored in START.
- WAIT: latency counter increments each cycle, value 1 in the first WAIT cycle.
  - If sdspi_finish=1: cycles = counter value (finish in first WAIT cycle gives 1), timeout=0 -> DONE.
  - Else if counter == TIMEOUT_CYCLES: cycles = TIMEOUT_CYCLES, timeout=1 -> DONE. Finish takes priority if both occur in the same cycle.
- DONE (1 cycle): done=1, result_valid=1, sdspi_rst=1, mux=0, busy=1 -> IDLE.
- Config outputs hold their values until the next accepted go.
- go while busy (including DONE) is ignored; config is not re-latched.
- Counter width is 32 bits and never wraps, since TIMEOUT_CYCLES < 2^32.
- Reset mid-run: immediate return to reset values. The UUT is held in reset and the pins return to autotest; no done pulse.
- All outputs are registered. Config inputs are sampled only on an accepted go.

Decomposition:
- Package sdspi_measure_pkg holds:
  - state encoding (6 states, 3 bits)
  - widths: N_BLOCKS_W=32, SPEED_W=5, CNT_W=32
  - mux select constants: SEL_AUTOTEST=0, SEL_UUT=1
- One sub-module, measure_counter: 32-bit counter with clear, enable and terminal-compare against a load value. Instantiated once for reset hold and once for latency.

Test Plan:
1. Reset: hold rst=0 for 5 cycles -> sdspi_rst=1, mux=0, start=0, busy=0, result_valid=0, cycles=0.
2. Nominal (RST_HOLD_CYCLES=4, TIMEOUT_CYCLES=1000): go with n_blocks=8, speed=3, cmd18=1; model raises finish 50 cycles after start.
   - start pulses exactly cycle 6 after go; config stable from cycle 1.
   - done pulse, cycles=50, timeout=0, result_valid=1, mux back to 0.
3. Timeout: same setup, finish never asserted -> done after 1000 WAIT cycles, cycles=1000, timeout=1, sdspi_rst=1.
4. go while busy: second go with n_blocks=99 at cycle 20 -> no restart, sdspi_n_blocks stays 8, single done pulse.
5. Async reset at WAIT cycle 10 -> same-cycle reset values, no done, a following go starts a clean run.
6. Back-to-back: go the cycle after done with finish at 3 cycles.
   - result_valid drops on the go cycle; new result cycles=3.
   - Also check finish=1 during START is ignored.

Source files
------------

// File: rtl/sdspi_measure_pkg.sv
// rtl/sdspi_measure_pkg.sv - shared types and constants for the SD-SPI measurement controller
package sdspi_measure_pkg;

  localparam int N_BLOCKS_W = 32;
  localparam int SPEED_W    = 5;
  localparam int CNT_W      = 32;

  localparam logic SEL_AUTOTEST = 1'b0;
  localparam logic SEL_UUT      = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST_UUT,
    ST_RELEASE,
    ST_START,
    ST_WAIT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/measure_counter.sv
// rtl/measure_counter.sv - up counter with clear, enable and terminal compare against a load value
module measure_counter
  import sdspi_measure_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] load,
  output logic [W-1:0] count,
  output logic         hit
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  assign hit = (count == load);

endmodule

// File: rtl/sdspi_measure_ctrl.sv
// rtl/sdspi_measure_ctrl.sv - resets and starts the SD-SPI UUT, then measures its latency to finish
module sdspi_measure_ctrl
  import sdspi_measure_pkg::*;
#(
  parameter int              RST_HOLD_CYCLES = 16,
  parameter logic [CNT_W-1:0] TIMEOUT_CYCLES  = 32'd100000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic [N_BLOCKS_W-1:0] cfg_n_blocks,
  input  logic [SPEED_W-1:0]    cfg_sclk_speed,
  input  logic                  cfg_cmd18,
  output logic                  sdspi_ctrl_mux,
  output logic                  sdspi_rst,
  output logic                  sdspi_start,
  output logic [N_BLOCKS_W-1:0] sdspi_n_blocks,
  output logic [SPEED_W-1:0]    sdspi_sclk_speed,
  output logic                  sdspi_cmd18,
  input  logic                  sdspi_finish,
  output logic                  busy,
  output logic                  done,
  output logic                  result_valid,
  output logic                  timeout,
  output logic [CNT_W-1:0]      cycles
);

  // Both counters read one behind the cycle they are in, so they compare against N-1.
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = TIMEOUT_CYCLES - CNT_W'(1);

  state_t           state;
  logic             hold_hit;
  logic [CNT_W-1:0] hold_count_unused;
  logic             lat_hit;
  logic [CNT_W-1:0] lat_count;
  logic [CNT_W-1:0] lat_now;

  measure_counter #(.W(CNT_W)) u_hold_cnt (
    .clk   (clk),
    .rst_n (rst),
    .clear (state == ST_IDLE),
    .en    (state == ST_RST_UUT),
    .load  (HOLD_LAST),
    .count (hold_count_unused),
    .hit   (hold_hit)
  );

  measure_counter #(.W(CNT_W)) u_lat_cnt (
    .clk   (clk),
    .rst_n (rst),
    .clear (state == ST_START),
    .en    (state == ST_WAIT),
    .load  (TIMEOUT_LAST),
    .count (lat_count),
    .hit   (lat_hit)
  );

  // Latency including the current WAIT cycle: 1 in the first WAIT cycle.
  assign lat_now = lat_count + CNT_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= ST_IDLE;
      sdspi_ctrl_mux   <= SEL_AUTOTEST;
      sdspi_rst        <= 1'b1;
      sdspi_start      <= 1'b0;
      sdspi_n_blocks   <= '0;
      sdspi_sclk_speed <= '0;
      sdspi_cmd18      <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      result_valid     <= 1'b0;
      timeout          <= 1'b0;
      cycles           <= '0;
    end else begin
      sdspi_start <= 1'b0;
      done        <= 1'b0;
      case (state)
        ST_IDLE: begin
          busy <= 1'b0;
          if (go) begin
            sdspi_n_blocks   <= cfg_n_blocks;
            sdspi_sclk_speed <= cfg_sclk_speed;
            sdspi_cmd18      <= cfg_cmd18;
            result_valid     <= 1'b0;
            timeout          <= 1'b0;
            cycles           <= '0;
            busy             <= 1'b1;
            sdspi_ctrl_mux   <= SEL_UUT;
            state            <= ST_RST_UUT;
          end
        end
        ST_RST_UUT: begin
          if (hold_hit) begin
            sdspi_rst <= 1'b0;
            state     <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          sdspi_start <= 1'b1;
          state       <= ST_START;
        end
        ST_START: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // Finish wins over timeout when both land on the same cycle.
          if (sdspi_finish || lat_hit) begin
            cycles         <= sdspi_finish ? lat_now : TIMEOUT_CYCLES;
            timeout        <= !sdspi_finish;
            done           <= 1'b1;
            result_valid   <= 1'b1;
            sdspi_rst      <= 1'b1;
            sdspi_ctrl_mux <= SEL_AUTOTEST;
            state          <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdspi_measure_ctrl.sv
// tb/tb_sdspi_measure_ctrl.sv - directed self-checking bench for sdspi_measure_ctrl
module tb_sdspi_measure_ctrl;

  localparam int H = 4;
  localparam int T = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        go;
  logic [31:0] cfg_n_blocks;
  logic [4:0]  cfg_sclk_speed;
  logic        cfg_cmd18;
  logic        sdspi_ctrl_mux;
  logic        sdspi_rst;
  logic        sdspi_start;
  logic [31:0] sdspi_n_blocks;
  logic [4:0]  sdspi_sclk_speed;
  logic        sdspi_cmd18;
  logic        sdspi_finish;
  logic        busy;
  logic        done;
  logic        result_valid;
  logic        timeout;
  logic [31:0] cycles;

  int checks = 0;
  int errors = 0;

  sdspi_measure_ctrl #(.RST_HOLD_CYCLES(H), .TIMEOUT_CYCLES(32'(T))) dut (
    .clk              (clk),
    .rst              (rst),
    .go               (go),
    .cfg_n_blocks     (cfg_n_blocks),
    .cfg_sclk_speed   (cfg_sclk_speed),
    .cfg_cmd18        (cfg_cmd18),
    .sdspi_ctrl_mux   (sdspi_ctrl_mux),
    .sdspi_rst        (sdspi_rst),
    .sdspi_start      (sdspi_start),
    .sdspi_n_blocks   (sdspi_n_blocks),
    .sdspi_sclk_speed (sdspi_sclk_speed),
    .sdspi_cmd18      (sdspi_cmd18),
    .sdspi_finish     (sdspi_finish),
    .busy             (busy),
    .done             (done),
    .result_valid     (result_valid),
    .timeout          (timeout),
    .cycles           (cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_sdspi_rst"}, 32'(sdspi_rst), 1);
    check({tag, "_mux"}, 32'(sdspi_ctrl_mux), 0);
    check({tag, "_start"}, 32'(sdspi_start), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_rv"}, 32'(result_valid), 0);
    check({tag, "_timeout"}, 32'(timeout), 0);
    check({tag, "_cycles"}, cycles, 0);
    check({tag, "_n_blocks"}, sdspi_n_blocks, 0);
  endtask

  // Cycle c = 1 is the first cycle after the accepted go edge. Returns in the
  // first idle cycle after done, or after a mid-run reset has been released.
  task automatic run(input logic [31:0] nb, input logic [4:0] sp, input logic c18,
                     input int fin_after, input int busy_go_at, input bit fin_in_start,
                     input int rst_at, output int start_cyc, output int done_cyc,
                     output int n_start, output int n_done, output bit cfg_ok);
    int c;
    bit finished;
    start_cyc = 0; done_cyc = 0; n_start = 0; n_done = 0; cfg_ok = 1; finished = 0;
    cfg_n_blocks = nb; cfg_sclk_speed = sp; cfg_cmd18 = c18;
    go = 1'b1;
    tick();
    go = 1'b0;
    c = 1;
    check("go_rv_cleared", 32'(result_valid), 0);
    check("go_busy", 32'(busy), 1);
    check("go_mux_uut", 32'(sdspi_ctrl_mux), 1);
    while (c < T + 100) begin
      if (sdspi_start) begin n_start++; start_cyc = c; end
      if (done) begin n_done++; done_cyc = c; sdspi_finish = 1'b0; end
      if (busy && (sdspi_n_blocks !== nb || sdspi_sclk_speed !== sp || sdspi_cmd18 !== c18))
        cfg_ok = 0;
      if (!busy) begin finished = 1; break; end
      go = (c == busy_go_at);
      cfg_n_blocks = go ? 32'd99 : nb;
      if (fin_in_start && sdspi_start) sdspi_finish = 1'b1;
      else if (start_cyc > 0 && fin_after > 0 && c == start_cyc + fin_after) sdspi_finish = 1'b1;
      else if (fin_in_start && start_cyc > 0 && c == start_cyc + 1) sdspi_finish = 1'b0;
      if (rst_at > 0 && start_cyc > 0 && c == start_cyc + rst_at) begin
        #2 rst = 1'b0;
        #1;
        check_reset_values("midrun");
        repeat (3) begin
          tick();
          if (done) n_done++;
        end
        rst = 1'b1;
        tick();
        finished = 1;
        break;
      end
      tick();
      c++;
    end
    check("run_finished_in_budget", 32'(finished), 1);
  endtask

  int  s_cyc, d_cyc, n_st, n_dn;
  bit  cfg_ok;

  initial begin
    rst = 1'b0; go = 1'b0; sdspi_finish = 1'b0;
    cfg_n_blocks = '0; cfg_sclk_speed = '0; cfg_cmd18 = 1'b0;
    repeat (5) tick();
    check_reset_values("reset");
    rst = 1'b1;
    tick();

    // Nominal run with a rejected second go at cycle 20.
    run(32'd8, 5'd3, 1'b1, 50, 20, 1'b0, 0, s_cyc, d_cyc, n_st, n_dn, cfg_ok);
    check("nom_start_cycle", 32'(s_cyc), H + 2);
    check("nom_start_count", 32'(n_st), 1);
    check("nom_done_count", 32'(n_dn), 1);
    check("nom_done_cycle", 32'(d_cyc), H + 2 + 50 + 1);
    check("nom_cfg_stable", 32'(cfg_ok), 1);
    check("nom_cycles", cycles, 50);
    check("nom_timeout", 32'(timeout), 0);
    check("nom_rv", 32'(result_valid), 1);
    check("nom_mux", 32'(sdspi_ctrl_mux), 0);
    check("nom_sdspi_rst", 32'(sdspi_rst), 1);
    check("nom_n_blocks", sdspi_n_blocks, 8);

    // Timeout with finish never raised.
    run(32'd16, 5'd1, 1'b0, 0, 0, 1'b0, 0, s_cyc, d_cyc, n_st, n_dn, cfg_ok);
    check("to_done_cycle", 32'(d_cyc), H + 2 + T + 1);
    check("to_done_count", 32'(n_dn), 1);
    check("to_cycles", cycles, T);
    check("to_timeout", 32'(timeout), 1);
    check("to_sdspi_rst", 32'(sdspi_rst), 1);
    check("to_rv", 32'(result_valid), 1);

    // Asynchronous reset at WAIT cycle 10, then a clean run.
    run(32'd5, 5'd2, 1'b1, 0, 0, 1'b0, 10, s_cyc, d_cyc, n_st, n_dn, cfg_ok);
    check("rst_no_done", 32'(n_dn), 0);
    run(32'd3, 5'd4, 1'b0, 5, 0, 1'b0, 0, s_cyc, d_cyc, n_st, n_dn, cfg_ok);
    check("post_rst_start_cycle", 32'(s_cyc), H + 2);
    check("post_rst_done_cycle", 32'(d_cyc), H + 2 + 5 + 1);
    check("post_rst_cycles", cycles, 5);
    check("post_rst_cfg", 32'(cfg_ok), 1);

    // Back-to-back go the cycle after done; finish during START must be ignored.
    check("b2b_rv_before_go", 32'(result_valid), 1);
    run(32'd7, 5'd9, 1'b1, 3, 0, 1'b1, 0, s_cyc, d_cyc, n_st, n_dn, cfg_ok);
    check("b2b_done_cycle", 32'(d_cyc), H + 2 + 3 + 1);
    check("b2b_cycles", cycles, 3);
    check("b2b_timeout", 32'(timeout), 0);
    check("b2b_sclk_speed", 32'(sdspi_sclk_speed), 9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
